// File: rtl/lsu_bus_if.sv
// Signal bundle between the EX stage, the load/store unit and data memory.
// The slave modport is the LSU's view; master is the EX stage plus memory side.
interface lsu_bus_if;
  logic        valid_i;
  logic        is_load_i;
  logic        is_store_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  access_size_i;
  logic        unsigned_load_i;

  logic        ready_o;
  logic        done_o;
  logic        align_err_o;
  logic        is_load_o;
  logic        unsigned_load_o;
  logic [1:0]  byte_lane_o;
  logic [1:0]  access_size_o;
  logic [31:0] rdata_o;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport slave (
    input  valid_i, is_load_i, is_store_i, addr_i, wdata_i, access_size_i,
           unsigned_load_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output ready_o, done_o, align_err_o, is_load_o, unsigned_load_o,
           byte_lane_o, access_size_o, rdata_o,
           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
  );

  modport master (
    output valid_i, is_load_i, is_store_i, addr_i, wdata_i, access_size_i,
           unsigned_load_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  ready_o, done_o, align_err_o, is_load_o, unsigned_load_o,
           byte_lane_o, access_size_o, rdata_o,
           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
  );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: one outstanding op, alignment check,
// byte-enable/data lane steering and a req/gnt/rvalid memory handshake.
module lsu_bus (
  input logic     clk_i,
  input logic     rst_i,
  lsu_bus_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        misaligned;
  logic        ready;
  logic        req;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  logic        done_q;
  logic        align_err_q;
  logic        is_load_q;
  logic        unsigned_load_q;
  logic [1:0]  byte_lane_q;
  logic [1:0]  access_size_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [31:0] daddr_q;
  logic [3:0]  be_q;
  logic [31:0] dwdata_q;

  always_comb begin
    misaligned = 1'b0;
    unique case (bus.access_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.addr_i[0];
      2'b10:   misaligned = |bus.addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.wdata_i;
    unique case (bus.access_size_i)
      2'b00: begin
        be_d    = 4'b0001 << bus.addr_i[1:0];
        wdata_d = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << bus.addr_i[1:0];
        wdata_d = {2{bus.wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = bus.wdata_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ready   = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_i && (bus.is_load_i || bus.is_store_i)) begin
          accept  = 1'b1;
          state_d = misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (bus.dmem_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (bus.dmem_rvalid_i) state_d = IDLE;
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q          <= 1'b0;
      align_err_q     <= 1'b0;
      is_load_q       <= 1'b0;
      unsigned_load_q <= 1'b0;
      byte_lane_q     <= '0;
      access_size_q   <= '0;
      rdata_q         <= '0;
      we_q            <= 1'b0;
      daddr_q         <= '0;
      be_q            <= '0;
      dwdata_q        <= '0;
    end else begin
      done_q <= (state_q == ERR) || ((state_q == RESP) && bus.dmem_rvalid_i);
      if (accept) begin
        align_err_q     <= misaligned;
        is_load_q       <= bus.is_load_i;
        unsigned_load_q <= bus.unsigned_load_i;
        byte_lane_q     <= bus.addr_i[1:0];
        access_size_q   <= bus.access_size_i;
        // Misaligned ops never reach the bus, so its outputs keep the last request.
        if (!misaligned) begin
          we_q     <= bus.is_store_i;
          daddr_q  <= {bus.addr_i[31:2], 2'b00};
          be_q     <= be_d;
          dwdata_q <= wdata_d;
        end
      end
      if ((state_q == RESP) && bus.dmem_rvalid_i && is_load_q) begin
        rdata_q <= bus.dmem_rdata_i;
      end
    end
  end

  assign bus.ready_o         = ready;
  assign bus.dmem_req_o      = req;
  assign bus.done_o          = done_q;
  assign bus.align_err_o     = align_err_q;
  assign bus.is_load_o       = is_load_q;
  assign bus.unsigned_load_o = unsigned_load_q;
  assign bus.byte_lane_o     = byte_lane_q;
  assign bus.access_size_o   = access_size_q;
  assign bus.rdata_o         = rdata_q;
  assign bus.dmem_we_o       = we_q;
  assign bus.dmem_addr_o     = daddr_q;
  assign bus.dmem_be_o       = be_q;
  assign bus.dmem_wdata_o    = dwdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Self-checking bench for lsu_bus: vector table with a scoreboard queue,
// plus directed back-to-back, reset-abort and spurious-handshake sequences.
module tb_lsu_bus;

  logic clk;
  logic rst;

  lsu_bus_if bus ();

  lsu_bus dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int unsigned gnt_dly;
    int unsigned rsp_dly;
    logic        spur;
    logic [31:0] mem_rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic        ld;
    logic        uns;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int unsigned checks;
  int unsigned errors;
  vec_t vecs[11];

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input int unsigned gd, input int unsigned rd, input logic spur,
                              input logic [31:0] mrd, input logic err, input logic [3:0] be,
                              input logic [31:0] daddr, input logic [31:0] dwdata);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.gnt_dly = gd; v.rsp_dly = rd; v.spur = spur; v.mem_rdata = mrd; v.err = err;
    v.be = be; v.daddr = daddr; v.dwdata = dwdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_i = 1'b0; bus.is_load_i = 1'b0; bus.is_store_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0; bus.access_size_i = '0; bus.unsigned_load_i = 1'b0;
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_req"}, 32'(bus.dmem_req_o), 32'd0);
    chk({tag, "_we"}, 32'(bus.dmem_we_o), 32'd0);
    chk({tag, "_be"}, 32'(bus.dmem_be_o), 32'd0);
    chk({tag, "_addr"}, bus.dmem_addr_o, 32'd0);
    chk({tag, "_wdata"}, bus.dmem_wdata_o, 32'd0);
    chk({tag, "_rdata"}, bus.rdata_o, 32'd0);
    chk({tag, "_attrs"}, 32'({bus.align_err_o, bus.is_load_o, bus.unsigned_load_o,
                              bus.byte_lane_o, bus.access_size_o}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    int unsigned reqc;
    bit          granted;
    @(negedge clk);
    chk("ready_idle", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1; bus.is_load_i = v.ld; bus.is_store_i = v.st; bus.addr_i = v.addr;
    bus.wdata_i = v.wdata; bus.access_size_i = v.size; bus.unsigned_load_i = v.uns;
    @(negedge clk);
    bus.valid_i = 1'b0; bus.is_load_i = 1'b0; bus.is_store_i = 1'b0;
    e.err = v.err; e.ld = v.ld; e.uns = v.uns; e.lane = v.addr[1:0]; e.size = v.size;
    e.rdata = v.mem_rdata;
    sbq.push_back(e);
    if (v.err) begin
      chk("err_no_req", 32'(bus.dmem_req_o), 32'd0);
      chk("err_flag", 32'(bus.align_err_o), 32'd1);
      chk("err_no_early_done", 32'(bus.done_o), 32'd0);
      @(negedge clk);
    end else begin
      reqc = 0;
      granted = 0;
      for (int i = 0; i < 16 && !granted; i++) begin
        if (bus.dmem_req_o === 1'b1) begin
          reqc++;
          chk("req_addr", bus.dmem_addr_o, v.daddr);
          chk("req_be", 32'(bus.dmem_be_o), 32'(v.be));
          chk("req_we", 32'(bus.dmem_we_o), 32'(v.st));
          if (v.st) chk("req_wdata", bus.dmem_wdata_o, v.dwdata);
        end
        if (reqc == v.gnt_dly + 1) begin
          bus.dmem_gnt_i = 1'b1;
          if (v.spur) begin
            bus.dmem_rvalid_i = 1'b1;
            bus.dmem_rdata_i = 32'hBAD0BAD0;
          end
          granted = 1;
        end
        @(negedge clk);
        bus.dmem_gnt_i = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
      end
      chk("req_cycles", reqc, v.gnt_dly + 1);
      chk("resp_req_low", 32'(bus.dmem_req_o), 32'd0);
      for (int i = 0; i < int'(v.rsp_dly); i++) begin
        if (v.spur) bus.dmem_gnt_i = 1'b1;
        @(negedge clk);
        bus.dmem_gnt_i = 1'b0;
        chk("resp_wait_no_done", 32'(bus.done_o), 32'd0);
      end
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i = v.mem_rdata;
      @(negedge clk);
      bus.dmem_rvalid_i = 1'b0;
      bus.dmem_rdata_i = '0;
    end
    if (bus.done_o === 1'b1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      chk("done_align_err", 32'(bus.align_err_o), 32'(e.err));
      chk("done_is_load", 32'(bus.is_load_o), 32'(e.ld));
      chk("done_unsigned", 32'(bus.unsigned_load_o), 32'(e.uns));
      chk("done_lane", 32'(bus.byte_lane_o), 32'(e.lane));
      chk("done_size", 32'(bus.access_size_o), 32'(e.size));
      if (e.ld && !e.err) chk("done_rdata", bus.rdata_o, e.rdata);
    end else begin
      chk("done_pulse", 32'(bus.done_o), 32'd1);
    end
    chk("done_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_state("rst_async");
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("rst_held");
    rst = 1'b0;

    //            ld  st  addr          wdata         sz     uns gd rd spur mem_rdata     err be       daddr         dwdata
    vecs[0]  = mk(0, 1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 0, 2, 0, 0, 32'h0,        0, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB);
    vecs[1]  = mk(1, 0, 32'h0000_2002, 32'h0,         2'b01, 1, 0, 0, 0, 32'hBEEF_1234, 0, 4'b1100, 32'h0000_2000, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0000_3001, 32'h0,         2'b10, 0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0,         32'h0);
    vecs[3]  = mk(0, 1, 32'h0000_4000, 32'h1234_CDEF, 2'b01, 0, 1, 1, 0, 32'h0,        0, 4'b0011, 32'h0000_4000, 32'hCDEF_CDEF);
    vecs[4]  = mk(0, 1, 32'h0000_5004, 32'hDEAD_BEEF, 2'b10, 0, 0, 2, 0, 32'h0,        0, 4'b1111, 32'h0000_5004, 32'hDEAD_BEEF);
    vecs[5]  = mk(1, 0, 32'h0000_6001, 32'h0,         2'b00, 0, 3, 0, 0, 32'h1122_3344, 0, 4'b0010, 32'h0000_6000, 32'h0);
    vecs[6]  = mk(0, 1, 32'h0000_7001, 32'h0000_5555, 2'b01, 0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0,         32'h0);
    vecs[7]  = mk(1, 0, 32'h0000_8000, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0,         32'h0);
    vecs[8]  = mk(1, 0, 32'h0000_9008, 32'h0,         2'b10, 1, 0, 3, 1, 32'hCAFE_F00D, 0, 4'b1111, 32'h0000_9008, 32'h0);
    vecs[9]  = mk(0, 1, 32'h0000_A000, 32'h0000_01FF, 2'b00, 0, 1, 0, 0, 32'h0,        0, 4'b0001, 32'h0000_A000, 32'hFFFF_FFFF);
    vecs[10] = mk(1, 0, 32'h0000_B003, 32'h0,         2'b01, 0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0,         32'h0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    // Back-to-back word stores: second op waits on valid and enters in the done cycle.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.is_store_i = 1'b1; bus.access_size_i = 2'b10;
    bus.addr_i = 32'h0000_C000; bus.wdata_i = 32'h1111_1111;
    @(negedge clk);
    bus.addr_i = 32'h0000_C010; bus.wdata_i = 32'h2222_2222;
    chk("b2b_req1", 32'(bus.dmem_req_o), 32'd1);
    chk("b2b_addr1", bus.dmem_addr_o, 32'h0000_C000);
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    bus.dmem_gnt_i = 1'b0;
    chk("b2b_resp_addr1", bus.dmem_addr_o, 32'h0000_C000);
    chk("b2b_resp_not_ready", 32'(bus.ready_o), 32'd0);
    bus.dmem_rvalid_i = 1'b1;
    @(negedge clk);
    bus.dmem_rvalid_i = 1'b0;
    chk("b2b_done1", 32'(bus.done_o), 32'd1);
    chk("b2b_ready_in_done", 32'(bus.ready_o), 32'd1);
    chk("b2b_addr_held", bus.dmem_addr_o, 32'h0000_C000);
    @(negedge clk);
    idle_inputs();
    chk("b2b_done_cleared", 32'(bus.done_o), 32'd0);
    chk("b2b_req2", 32'(bus.dmem_req_o), 32'd1);
    chk("b2b_addr2", bus.dmem_addr_o, 32'h0000_C010);
    chk("b2b_wdata2", bus.dmem_wdata_o, 32'h2222_2222);
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    bus.dmem_gnt_i = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    @(negedge clk);
    bus.dmem_rvalid_i = 1'b0;
    chk("b2b_done2", 32'(bus.done_o), 32'd1);

    // Reset while waiting for rvalid aborts the load; a late rvalid is dropped.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.is_load_i = 1'b1; bus.access_size_i = 2'b10; bus.addr_i = 32'h0000_D000;
    @(negedge clk);
    idle_inputs();
    chk("rst_txn_req", 32'(bus.dmem_req_o), 32'd1);
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    bus.dmem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    bus.dmem_rvalid_i = 1'b0;
    chk("late_rvalid_no_done", 32'(bus.done_o), 32'd0);
    chk("late_rvalid_rdata", bus.rdata_o, 32'd0);
    @(negedge clk);
    chk("late_rvalid_ready", 32'(bus.ready_o), 32'd1);
    chk("late_rvalid_no_done2", 32'(bus.done_o), 32'd0);

    // Spurious gnt/rvalid in IDLE.
    bus.dmem_rvalid_i = 1'b1; bus.dmem_gnt_i = 1'b1; bus.dmem_rdata_i = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    chk("idle_spur_no_done", 32'(bus.done_o), 32'd0);
    chk("idle_spur_ready", 32'(bus.ready_o), 32'd1);
    chk("idle_spur_no_req", 32'(bus.dmem_req_o), 32'd0);
    chk("idle_spur_rdata", bus.rdata_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
